micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Microprogrammed control unit that sits directly upstream of the register ALU. It holds a writable control store of microinstructions and steps a microprogram counter through them. Each cycle it drives the full RALU control word: S, M, Pin, ISR, ISL, A, wr, adr, v and the 4-bit DataIn immediate. Sequencing supports conditional branches on RALU status (Pout, OSL, OSR, R==0), a loop counter, and a start/busy/done handshake toward the central unit.

## Interface
- AW, 5: control-store address width. Depth is 2^AW words. Microword width is MW = 26+AW.
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin microprogram at start_addr; sampled only in IDLE
- start_addr  in  AW  entry address
- prog_we  in  1  control-store write enable; honoured only in IDLE
- prog_addr  in  AW  write address
- prog_data  in  MW  microword to write
- Pout, OSL, OSR  in  1 each  RALU status outputs
- R  in  4  RALU result, used for zero condition
- S  out  4, M  out  1, Pin  out  1, ISR  out  1, ISL  out  1, A  out  1, wr  out  1, adr  out  3, v  out  4: RALU control fields
- DataIn  out  4  immediate operand to RALU
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse after END executes

## Operation
- Microword layout, MSB first: S[4], M, Pin, ISR, ISL, A, wr, adr[3], v[4], imm[4], op[3], cond[2], target[AW]. With AW=5 the fields sit at S=[30:27], imm=[13:10], op=[9:7], cond=[6:5], target=[4:0].
- Control store: 2^AW x MW array. Write is synchronous. Read is asynchronous, feeding the microinstruction register MIR. Contents are not cleared by reset.
- All RALU control outputs and DataIn come directly from MIR fields. MIR is all-zero in IDLE, which makes it a NOP: wr=0, v=0, A=0.
- cond select:
  - 00: Pout
  - 01: OSL
  - 10: OSR
  - 11: R==4'b0000
  - The condition is evaluated combinationally in the same cycle the MIR word drives the RALU.
- op values and next address (upc = address of the current MIR word; upc+1 wraps modulo 2^AW):
  - 000 CONT: next = upc+1
  - 001 JMP: next = target
  - 010 BRT: next = cond ? target : upc+1
  - 011 BRF: next = cond ? upc+1 : target
  - 100 LDCNT: cnt <= target; next = upc+1
  - 101 LOOP: if cnt!=0 then cnt <= cnt-1 and next = target; else next = upc+1
  - 110 END: the word's RALU fields execute this cycle, then return to IDLE
  - 111: reserved, behaves as CONT
- FSM has two states:
  - IDLE: busy=0. A start high in this state causes MIR <= mem[start_addr], upc <= start_addr, and a move to RUN.
  - RUN: busy=1. Each cycle MIR <= mem[next] and upc <= next. On END: MIR <= 0, done <= 1, and a move to IDLE.
- cnt is AW bits wide, unsigned, and never underflows: LOOP with cnt=0 falls through.

## Timing
- Reset values: state=IDLE, upc=0, MIR=0 (so every RALU control output and DataIn is 0), cnt=0, busy=0, done=0.
- Latency: the first microword drives the RALU in the cycle after start is sampled. After that, one microword executes per cycle with no bubbles, including on taken branches.
- done is high for exactly one cycle: the cycle after the END word executes. busy is already 0 in that cycle. A new start is accepted in that same cycle.
- start while in RUN is ignored. prog_we while in RUN is ignored, and the store is unchanged.
- start and prog_we in the same IDLE cycle: both take effect. If prog_addr==start_addr, MIR loads the pre-write contents.
- Reset asserted in RUN: on the next edge all state is forced to reset values. done does not pulse and the control store is preserved.
- A JMP to its own address loops indefinitely. Only reset exits this case.

## Test plan
- Reset, then observe outputs -> S=0, v=0, wr=0, DataIn=0, busy=0, done=0 every cycle while start=0.
- Program addr0={imm=3,A=1,v=0001,CONT}, addr1={wr=1,adr=0,CONT}, addr2={END}. Pulse start with start_addr=0 -> DataIn=3/A=1 in cycle 1, wr=1/adr=0 in cycle 2, END word in cycle 3, done=1 and busy=0 in cycle 4.
- Branch: addr4={cond=11,op=BRT,target=9}. With R=0 -> next word fetched from addr9. With R=5 -> next word fetched from addr5. Repeat with op=BRF and confirm the opposite targets.
- Loop: addr0={LDCNT,target=2}, addr1={S=0101,v=0010,LOOP,target=1}, addr2={END} -> addr1 executes 3 times (cnt 2→1→0, then fall through), done asserts on the 6th cycle after start.
- Wrap and guards: program addr31=CONT and addr0=END, start at 31 -> 0 executes after 31. While busy, pulse start and prog_we -> no effect, and a store readback via a later program run shows the old contents.
- Reset mid-run: start a 10-word program and assert reset in its 4th cycle -> the next cycle has all outputs 0 and busy=0. A restart then runs the unchanged program from start_addr.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit driving the register ALU from a writable control store.
// Latency: first microword drives the RALU one cycle after start; then one word per cycle, no bubbles.
// Backpressure: none; start and store writes are accepted only in IDLE and ignored while busy.
module micro_sequencer #(
   parameter int AW = 5,
   localparam int MW = 26 + AW
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic [AW-1:0] i_start_addr,
   input  logic          i_prog_we,
   input  logic [AW-1:0] i_prog_addr,
   input  logic [MW-1:0] i_prog_data,
   input  logic          i_pout,
   input  logic          i_osl,
   input  logic          i_osr,
   input  logic [3:0]    i_r,
   output logic [3:0]    o_s,
   output logic          o_m,
   output logic          o_pin,
   output logic          o_isr,
   output logic          o_isl,
   output logic          o_a,
   output logic          o_wr,
   output logic [2:0]    o_adr,
   output logic [3:0]    o_v,
   output logic [3:0]    o_data_in,
   output logic          o_busy,
   output logic          o_done
);

   // Microword field positions, LSB upward: target, cond, op, imm, v, adr, wr, A, ISL, ISR, Pin, M, S
   localparam int F_TGT  = 0;
   localparam int F_COND = AW;
   localparam int F_OP   = AW + 2;
   localparam int F_IMM  = AW + 5;
   localparam int F_V    = AW + 9;
   localparam int F_ADR  = AW + 13;
   localparam int F_WR   = AW + 16;
   localparam int F_A    = AW + 17;
   localparam int F_ISL  = AW + 18;
   localparam int F_ISR  = AW + 19;
   localparam int F_PIN  = AW + 20;
   localparam int F_M    = AW + 21;
   localparam int F_S    = AW + 22;

   localparam logic [2:0] OP_CONT  = 3'b000;
   localparam logic [2:0] OP_JMP   = 3'b001;
   localparam logic [2:0] OP_BRT   = 3'b010;
   localparam logic [2:0] OP_BRF   = 3'b011;
   localparam logic [2:0] OP_LDCNT = 3'b100;
   localparam logic [2:0] OP_LOOP  = 3'b101;
   localparam logic [2:0] OP_END   = 3'b110;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t        r_state;
   logic [AW-1:0] r_upc;
   logic [MW-1:0] r_mir;
   logic [AW-1:0] r_cnt;
   logic          r_busy;
   logic          r_done;
   logic [MW-1:0] r_mem [2**AW];

   logic [2:0]    w_op;
   logic [1:0]    w_cond_sel;
   logic [AW-1:0] w_target;
   logic [AW-1:0] w_upc_inc;
   logic          w_cond;
   logic          w_loop_taken;
   logic [AW-1:0] w_next;

   assign w_op         = r_mir[F_OP +: 3];
   assign w_cond_sel   = r_mir[F_COND +: 2];
   assign w_target     = r_mir[F_TGT +: AW];
   assign w_upc_inc    = r_upc + AW'(1);
   assign w_loop_taken = (w_op == OP_LOOP) && (r_cnt != '0);

   // RALU status condition, evaluated in the same cycle the word drives the RALU
   always_comb begin
      w_cond = 1'b0;
      case (w_cond_sel)
         2'b00:   w_cond = i_pout;
         2'b01:   w_cond = i_osl;
         2'b10:   w_cond = i_osr;
         default: w_cond = (i_r == 4'b0000);
      endcase
   end

   // Next microprogram address; reserved op and END fall back to sequential
   always_comb begin
      w_next = w_upc_inc;
      case (w_op)
         OP_JMP:  w_next = w_target;
         OP_BRT:  w_next = w_cond ? w_target : w_upc_inc;
         OP_BRF:  w_next = w_cond ? w_upc_inc : w_target;
         OP_LOOP: w_next = w_loop_taken ? w_target : w_upc_inc;
         default: w_next = w_upc_inc;
      endcase
   end

   // Control-store write port; the store is deliberately left out of reset
   always_ff @(posedge i_clock) begin
      if (i_prog_we && (r_state == ST_IDLE)) begin
         r_mem[i_prog_addr] <= i_prog_data;
      end
   end

   // Sequencer FSM: fetch into MIR, step upc, maintain loop counter and handshake
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_upc   <= '0;
         r_mir   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_mir   <= r_mem[i_start_addr];
                  r_upc   <= i_start_addr;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_op == OP_END) begin
                  r_mir   <= '0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_mir <= r_mem[w_next];
                  r_upc <= w_next;
                  if (w_op == OP_LDCNT) begin
                     r_cnt <= w_target;
                  end else if (w_loop_taken) begin
                     r_cnt <= r_cnt - AW'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_s       = r_mir[F_S +: 4];
   assign o_m       = r_mir[F_M];
   assign o_pin     = r_mir[F_PIN];
   assign o_isr     = r_mir[F_ISR];
   assign o_isl     = r_mir[F_ISL];
   assign o_a       = r_mir[F_A];
   assign o_wr      = r_mir[F_WR];
   assign o_adr     = r_mir[F_ADR +: 3];
   assign o_v       = r_mir[F_V +: 4];
   assign o_data_in = r_mir[F_IMM +: 4];
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer with a per-cycle expected-output scoreboard.
// Latency: each expected entry corresponds to one clock cycle of DUT output.
// Backpressure: not applicable; stimulus is cycle-driven.
module tb_micro_sequencer;
   localparam int AW = 5;
   localparam int MW = 26 + AW;

   localparam logic [2:0] CONT  = 3'b000;
   localparam logic [2:0] JMP   = 3'b001;
   localparam logic [2:0] BRT   = 3'b010;
   localparam logic [2:0] BRF   = 3'b011;
   localparam logic [2:0] LDCNT = 3'b100;
   localparam logic [2:0] LOOP  = 3'b101;
   localparam logic [2:0] ENDW  = 3'b110;

   logic          clk = 1'b0;
   logic          i_reset, i_start, i_prog_we, i_pout, i_osl, i_osr;
   logic [AW-1:0] i_start_addr, i_prog_addr;
   logic [MW-1:0] i_prog_data;
   logic [3:0]    i_r;
   logic [3:0]    o_s, o_v, o_data_in;
   logic          o_m, o_pin, o_isr, o_isl, o_a, o_wr, o_busy, o_done;
   logic [2:0]    o_adr;

   int n_tests = 0;
   int n_fail  = 0;
   logic [22:0]   sb_q [$];
   logic [MW-1:0] tb_mem [32];

   always #5 clk = ~clk;

   micro_sequencer #(.AW(AW)) dut (
      .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_start_addr(i_start_addr),
      .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data),
      .i_pout(i_pout), .i_osl(i_osl), .i_osr(i_osr), .i_r(i_r),
      .o_s(o_s), .o_m(o_m), .o_pin(o_pin), .o_isr(o_isr), .o_isl(o_isl), .o_a(o_a),
      .o_wr(o_wr), .o_adr(o_adr), .o_v(o_v), .o_data_in(o_data_in),
      .o_busy(o_busy), .o_done(o_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [22:0] obs_vec();
      return {o_s, o_m, o_pin, o_isr, o_isl, o_a, o_wr, o_adr, o_v, o_data_in, o_busy, o_done};
   endfunction

   function automatic logic [MW-1:0] mk(input logic [3:0] s, input logic [5:0] ctl,
                                        input logic [2:0] adr, input logic [3:0] v,
                                        input logic [3:0] imm, input logic [2:0] op,
                                        input logic [1:0] cnd, input logic [4:0] tgt);
      return {s, ctl, adr, v, imm, op, cnd, tgt};
   endfunction

   // expected output while a stored word executes: its RALU fields, busy=1, done=0
   task automatic exp_word(input int a);
      logic [MW-1:0] w;
      w = tb_mem[a];
      sb_q.push_back({w[30:10], 2'b10});
   endtask

   task automatic exp_done();
      sb_q.push_back({21'd0, 2'b01});
   endtask

   task automatic exp_idle();
      sb_q.push_back(23'd0);
   endtask

   task automatic step(input string tag);
      logic [22:0] e;
      @(posedge clk);
      #1;
      i_start   = 1'b0;
      i_prog_we = 1'b0;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty at output sample", tag);
      end else begin
         e = sb_q.pop_front();
         chk(tag, {9'd0, obs_vec()}, {9'd0, e});
      end
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (sb_q.size() > 0 && guard < 64) begin
         step(tag);
         guard++;
      end
   endtask

   task automatic prog(input int a, input logic [MW-1:0] w);
      i_prog_we   = 1'b1;
      i_prog_addr = AW'(a);
      i_prog_data = w;
      @(posedge clk);
      #1;
      i_prog_we = 1'b0;
      tb_mem[a] = w;
   endtask

   task automatic kick(input int a);
      i_start      = 1'b1;
      i_start_addr = AW'(a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [MW-1:0] new_w;
      i_reset = 1'b1; i_start = 1'b0; i_prog_we = 1'b0; i_pout = 1'b0; i_osl = 1'b0;
      i_osr = 1'b0; i_start_addr = '0; i_prog_addr = '0; i_prog_data = '0; i_r = 4'd0;

      // reset state
      @(posedge clk);
      #1;
      chk("reset", {9'd0, obs_vec()}, 32'd0);
      i_reset = 1'b0;
      repeat (3) exp_idle();
      drain("idle_after_reset");

      // straight-line program, then a restart accepted in the done cycle
      prog(0, mk(4'd0, 6'b000010, 3'd0, 4'b0001, 4'd3, CONT, 2'd0, 5'd0));
      prog(1, mk(4'd0, 6'b000001, 3'd0, 4'd0, 4'd0, CONT, 2'd0, 5'd0));
      prog(2, mk(4'd0, 6'b000000, 3'd0, 4'd0, 4'd0, ENDW, 2'd0, 5'd0));
      exp_word(0); exp_word(1); exp_word(2); exp_done();
      kick(0);
      repeat (4) step("basic");
      exp_word(0); exp_word(1); exp_word(2); exp_done(); exp_idle();
      kick(0);
      drain("restart_in_done");

      // conditional branches on R==0 and Pout
      prog(9, mk(4'd9, 6'b100000, 3'd1, 4'd0, 4'd0, ENDW, 2'd0, 5'd0));
      prog(5, mk(4'd5, 6'b010000, 3'd2, 4'd0, 4'd0, ENDW, 2'd0, 5'd0));
      prog(4, mk(4'd4, 6'b000000, 3'd0, 4'd0, 4'd0, BRT, 2'b11, 5'd9));
      i_r = 4'd0; exp_word(4); exp_word(9); exp_done(); kick(4); drain("brt_r0");
      i_r = 4'd5; exp_word(4); exp_word(5); exp_done(); kick(4); drain("brt_r5");
      prog(4, mk(4'd4, 6'b000000, 3'd0, 4'd0, 4'd0, BRF, 2'b11, 5'd9));
      i_r = 4'd0; exp_word(4); exp_word(5); exp_done(); kick(4); drain("brf_r0");
      i_r = 4'd5; exp_word(4); exp_word(9); exp_done(); kick(4); drain("brf_r5");
      prog(4, mk(4'd4, 6'b000000, 3'd0, 4'd0, 4'd0, BRT, 2'b00, 5'd9));
      i_pout = 1'b1; exp_word(4); exp_word(9); exp_done(); kick(4); drain("brt_pout1");
      i_pout = 1'b0; exp_word(4); exp_word(5); exp_done(); kick(4); drain("brt_pout0");

      // loop counter: body runs 3 times, done on the 6th cycle
      prog(0, mk(4'd0, 6'b000000, 3'd0, 4'd0, 4'd0, LDCNT, 2'd0, 5'd2));
      prog(1, mk(4'b0101, 6'b000000, 3'd0, 4'b0010, 4'd0, LOOP, 2'd0, 5'd1));
      prog(2, mk(4'hE, 6'b000000, 3'd0, 4'd0, 4'd0, ENDW, 2'd0, 5'd0));
      exp_word(0); exp_word(1); exp_word(1); exp_word(1); exp_word(2); exp_done(); exp_idle();
      kick(0);
      drain("loop");

      // upc wraps from 31 to 0
      prog(31, mk(4'd0, 6'b000000, 3'd0, 4'd0, 4'd7, CONT, 2'd0, 5'd0));
      prog(0, mk(4'd3, 6'b000000, 3'd0, 4'd0, 4'd0, ENDW, 2'd0, 5'd0));
      exp_word(31); exp_word(0); exp_done();
      kick(31);
      drain("wrap");

      // start and prog_we while busy are ignored
      for (int i = 20; i < 23; i++)
         prog(i, mk(4'(i - 19), 6'b000000, 3'(i), 4'd0, 4'(i), CONT, 2'd0, 5'd0));
      prog(23, mk(4'd8, 6'b000000, 3'd0, 4'd0, 4'd0, ENDW, 2'd0, 5'd0));
      exp_word(20); exp_word(21); exp_word(22); exp_word(23); exp_done(); exp_idle();
      kick(20);
      step("guard");
      i_start = 1'b1; i_start_addr = 5'd0;
      i_prog_we = 1'b1; i_prog_addr = 5'd22;
      i_prog_data = mk(4'hF, 6'b111111, 3'd7, 4'hF, 4'hF, CONT, 2'd0, 5'd0);
      drain("guard");
      exp_word(20); exp_word(21); exp_word(22); exp_word(23); exp_done();
      kick(20);
      drain("guard_readback");

      // start and write to the same address in one IDLE cycle: old word is fetched
      new_w = mk(4'hC, 6'b001100, 3'd5, 4'd6, 4'd9, CONT, 2'd0, 5'd0);
      i_prog_we = 1'b1; i_prog_addr = 5'd20; i_prog_data = new_w;
      exp_word(20); exp_word(21); exp_word(22); exp_word(23); exp_done();
      kick(20);
      drain("start_write_same");
      tb_mem[20] = new_w;
      exp_word(20); exp_word(21); exp_word(22); exp_word(23); exp_done();
      kick(20);
      drain("start_write_after");

      // reset in the 4th cycle of a 10-word program, then restart
      for (int i = 0; i < 9; i++)
         prog(i, mk(4'(i), 6'b000000, 3'd0, 4'(i), 4'(15 - i), CONT, 2'd0, 5'd0));
      prog(9, mk(4'd9, 6'b000000, 3'd0, 4'd0, 4'd0, ENDW, 2'd0, 5'd0));
      exp_word(0); exp_word(1); exp_word(2); exp_word(3);
      kick(0);
      drain("pre_reset");
      i_reset = 1'b1;
      exp_idle();
      drain("mid_reset");
      i_reset = 1'b0;
      exp_idle();
      drain("post_reset");
      for (int i = 0; i < 10; i++) exp_word(i);
      exp_done(); exp_idle();
      kick(0);
      drain("rerun");

      // self jump spins until reset
      prog(12, mk(4'd7, 6'b000011, 3'd3, 4'd1, 4'd2, JMP, 2'd0, 5'd12));
      repeat (6) exp_word(12);
      kick(12);
      drain("self_jmp");
      i_reset = 1'b1;
      exp_idle();
      drain("self_jmp_reset");
      i_reset = 1'b0;
      exp_idle();
      drain("self_jmp_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
